// File: rtl/scan_sel_gen.sv
// Select sequencer for the 2-to-4 decoder stage: walks sel 0..3 with a per-slot
// dwell, optional blank gap, single-step and direct-load control.
module scan_sel_gen #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       step_mode,
  input  logic       step,
  input  logic       load,
  input  logic [1:0] load_sel,
  output logic       s1,
  output logic       s0,
  output logic       sel_valid,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 32'd1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK == 0) ? 32'd0 : BLANK - 32'd1);
  localparam bit               HAS_GAP    = (BLANK != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q;
  logic             fd_q, fd_d;
  logic             slot_end;

  // State and output registers; sel_valid is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == ACTIVE);
      fd_q    <= fd_d;
    end
  end

  // Next-state: load beats disable, disable beats slot sequencing
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    fd_d     = 1'b0;
    slot_end = step_mode ? step : (cnt_q == DWELL_LAST);

    if (load) begin
      sel_d   = load_sel;
      cnt_d   = '0;
      state_d = en ? ACTIVE : IDLE;
    end else if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
        ACTIVE: begin
          if (slot_end) begin
            cnt_d = '0;
            if (HAS_GAP) begin
              state_d = GAP;
            end else begin
              sel_d = sel_q + 2'd1;
              fd_d  = (sel_q == 2'd3);
            end
          end else if (!step_mode) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == BLANK_LAST) begin
            sel_d   = sel_q + 2'd1;
            cnt_d   = '0;
            state_d = ACTIVE;
            fd_d    = (sel_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign s1         = sel_q[1];
  assign s0         = sel_q[0];
  assign sel_valid  = valid_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Scoreboard bench for scan_sel_gen: a DWELL=4/BLANK=1 instance and a
// DWELL=1/BLANK=0 instance, directed stimulus with hand-derived expectations.
module tb_scan_sel_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic       load = 1'b0;
  logic [1:0] load_sel = 2'b00;
  logic       en_b = 1'b0;
  logic       zero = 1'b0;
  logic [1:0] zero2 = 2'b00;

  logic s1_a, s0_a, v_a, fd_a;
  logic s1_b, s0_b, v_b, fd_b;

  always #5 clk = ~clk;

  scan_sel_gen #(.DWELL(4), .BLANK(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .step_mode(step_mode), .step(step),
    .load(load), .load_sel(load_sel),
    .s1(s1_a), .s0(s0_a), .sel_valid(v_a), .frame_done(fd_a)
  );

  scan_sel_gen #(.DWELL(1), .BLANK(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .step_mode(zero), .step(zero),
    .load(zero), .load_sel(zero2),
    .s1(s1_b), .s0(s0_b), .sel_valid(v_b), .frame_done(fd_b)
  );

  typedef struct {
    logic [3:0] exp;
    int         tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;
  int   tag = 0;

  // Expected word layout: {s1, s0, sel_valid, frame_done}
  task automatic chk(input string name, input int t, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s tag=%0d got {s1,s0,valid,fd}=%b expected=%b", name, t, act, exp);
    end
  endtask

  // Expectation for the edge following the current inputs, then advance a cycle
  task automatic ea(input logic [1:0] s, input logic v, input logic f);
    exp_t e;
    e.exp = {s, v, f};
    e.tag = tag;
    tag++;
    qa.push_back(e);
    @(negedge clk);
  endtask

  task automatic ea_n(input int n, input logic [1:0] s, input logic v, input logic f);
    for (int i = 0; i < n; i++) ea(s, v, f);
  endtask

  task automatic eb(input logic [1:0] s, input logic v, input logic f);
    exp_t e;
    e.exp = {s, v, f};
    e.tag = tag;
    tag++;
    qb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every cycle the DUT presents a new registered output
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("dut_a", e.tag, {s1_a, s0_a, v_a, fd_a}, e.exp);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("dut_b", e.tag, {s1_b, s0_b, v_b, fd_b}, e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a", -1, {s1_a, s0_a, v_a, fd_a}, 4'b0000);
    chk("reset_b", -1, {s1_b, s0_b, v_b, fd_b}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ea_n(2, 2'd0, 1'b0, 1'b0);

    // Free-run frame: 4 valid + 1 blank per slot, wrap pulse on return to 0
    en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ea_n(4, 2'(s), 1'b1, 1'b0);
      ea(2'(s), 1'b0, 1'b0);
    end
    ea(2'd0, 1'b1, 1'b1);
    ea(2'd0, 1'b1, 1'b0);

    // Load 2 mid-slot: fresh 4-cycle dwell
    load = 1'b1; load_sel = 2'd2;
    ea(2'd2, 1'b1, 1'b0);
    load = 1'b0;
    ea_n(3, 2'd2, 1'b1, 1'b0);
    ea(2'd2, 1'b0, 1'b0);
    ea_n(2, 2'd3, 1'b1, 1'b0);
    // Load 0 from sel 3: no wrap pulse
    load = 1'b1; load_sel = 2'd0;
    ea(2'd0, 1'b1, 1'b0);
    load = 1'b0;
    ea_n(3, 2'd0, 1'b1, 1'b0);
    ea(2'd0, 1'b0, 1'b0);
    ea_n(2, 2'd1, 1'b1, 1'b0);

    // Drop en mid-dwell at sel 1, then resume with a full dwell
    en = 1'b0;
    ea_n(2, 2'd1, 1'b0, 1'b0);
    en = 1'b1;
    ea_n(4, 2'd1, 1'b1, 1'b0);
    ea(2'd1, 1'b0, 1'b0);
    ea(2'd2, 1'b1, 1'b0);

    // Step mode: hold without step, step -> gap, step during gap ignored
    step_mode = 1'b1;
    ea_n(50, 2'd2, 1'b1, 1'b0);
    step = 1'b1;
    ea(2'd2, 1'b0, 1'b0);
    ea(2'd3, 1'b1, 1'b0);
    step = 1'b0;
    ea_n(3, 2'd3, 1'b1, 1'b0);
    step = 1'b1;
    ea(2'd3, 1'b0, 1'b0);
    step = 1'b0;
    step_mode = 1'b0;

    // Async reset mid-gap at sel 3: outputs clear before the next edge
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_a", -2, {s1_a, s0_a, v_a, fd_a}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    ea_n(2, 2'd0, 1'b1, 1'b0);

    // BLANK=0, DWELL=1: advance every cycle, wrap pulse every 4th
    en = 1'b0;
    en_b = 1'b1;
    eb(2'd0, 1'b1, 1'b0);
    for (int f = 0; f < 2; f++) begin
      eb(2'd1, 1'b1, 1'b0);
      eb(2'd2, 1'b1, 1'b0);
      eb(2'd3, 1'b1, 1'b0);
      eb(2'd0, 1'b1, 1'b1);
    end
    eb(2'd1, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    chk("queue_drain", -3, 4'(qa.size() + qb.size()), 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
